spi_debug_bridge: RTL and testbench
===================================

// Module: spi_debug_bridge
// PURPOSE
// - SPI-slave debug port feeding the cpu16/vga40x30 system from the board SPI pins.
// - Converts 32-bit host SPI frames into single-word read/write requests on the debug memory bus.
// - Returns read data and status to the host in the following frame.
// PARAMETERS
// - ADDR_W  15  debug bus address width; frame = 1 + ADDR_W + DATA_W bits
// - DATA_W  16  debug bus data width
// - SYNC    2   synchronizer depth for spi_clk/spi_mosi/spi_cs (>=2)
// PORTS
// - clk         in   1       system clock; all logic in this domain
// - rst_n       in   1       asynchronous, active-low reset
// - spi_clk     in   1       SPI SCLK, mode 0, async to clk; rate <= clk/8
// - spi_cs      in   1       SPI chip select, active low
// - spi_mosi    in   1       host->bridge data, MSB first
// - spi_miso    out  1       bridge->host data, MSB first
// - dbg_addr    out  ADDR_W  request address
// - dbg_wdata   out  DATA_W  write data
// - dbg_wr      out  1       request is a write (valid with dbg_req)
// - dbg_req     out  1       request valid; held until dbg_ack
// - dbg_ack     in   1       request accepted; for reads, dbg_rdata is valid in the same cycle
// - dbg_rdata   in   DATA_W  read data
// BEHAVIOUR
// - Reset: all outputs 0; shift regs, bit counter, rdata hold, flags cleared.
// - Inputs pass through SYNC flops; sclk rise/fall detected on synchronized copy.
// - Frame = bit31 wr, [30:16] addr, [15:0] data; shifted in on sclk rise while cs low.
// - Bit counter resets on cs falling edge; cs rising before 32 bits -> frame discarded, no request.
// - States: IDLE -> SHIFT (cs low) -> ISSUE (32nd bit) -> WAIT (dbg_req=1) -> IDLE/SHIFT on dbg_ack.
// - dbg_req asserts 1 clk after the synchronized 32nd rising edge; addr/wdata/wr stable until ack.
// - dbg_ack with dbg_req low is ignored.
// - Read ack: dbg_rdata captured into the hold register; write ack leaves the hold register unchanged.
// - Completed frame while WAIT -> frame dropped, sticky ovf=1; the pending request is unaffected.
// - ovf clears when a status word containing ovf=1 has been fully shifted out.
// - MISO word = {busy, ovf, 14'b0, rdata_hold}; busy = dbg_req at cs fall.
// - MISO: bit31 loaded on cs fall; next bit on each sclk fall; 0 when cs high.
// - Multiple frames per cs assertion allowed; counter wraps 31->0 and reloads the MISO word.
// - Async reset mid-request drops the request (dbg_req=0 immediately).
// CONFIGURATION
// - SPI_DBG_AUTOINC_EN defined:
//   - 2nd+ frame within one cs assertion ignores its addr field.
//   - Uses an internal pointer = previous request addr + 1, wrapping at 2^ADDR_W.
// - Undefined: every frame uses its own addr field; no pointer register.
// TESTING
// - Write 0x8123_BEEF -> one dbg_req, wr=1, addr=0x0123, wdata=0xBEEF; ack -> req low next clk.
// - Read 0x0042_0000, ack with rdata=0x1234 -> next frame MISO = 0x0000_1234.
// - cs high after 20 bits -> no dbg_req; next full frame is decoded normally.
// - Hold dbg_ack low, send 2 frames -> one request; next status has ovf=1; the following frame has ovf=0.
// - AUTOINC: one cs, frames write 0x8010_0001 then 0x8777_0002 -> addrs 0x0010, 0x0011 (0x0777 without macro).
// - rst_n low while dbg_req=1 -> dbg_req=0 and spi_miso=0 at once; fresh frame works after release.

Source files
------------

// File: rtl/spi_debug_bridge.sv
// spi_debug_bridge
//   SPI-slave (mode 0) debug port. Each host frame of 1+ADDR_W+DATA_W bits
//   ({wr, addr, data}, MSB first) becomes one read/write request on the debug
//   memory bus. The status word {busy, ovf, zeros, rdata_hold} is returned on
//   MISO during the following frame.
//
//   Optional feature: define SPI_DBG_AUTOINC_EN so that the 2nd and later
//   frames within one chip-select assertion use an auto-incremented address
//   (previous request address + 1) instead of their own addr field.
//
// Ports
//   clk, rst_n          system clock, asynchronous active-low reset
//   spi_clk/cs/mosi     SPI pins, asynchronous to clk (sclk <= clk/8)
//   spi_miso            status word out, MSB first, 0 while cs is high
//   dbg_addr/wdata/wr   request fields, stable while dbg_req is high
//   dbg_req             request valid, held until dbg_ack
//   dbg_ack, dbg_rdata  request accepted; read data valid with the ack
module spi_debug_bridge #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16,
  parameter int SYNC   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_clk,
  input  logic              spi_cs,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_wr,
  output logic              dbg_req,
  input  logic              dbg_ack,
  input  logic [DATA_W-1:0] dbg_rdata
);

  localparam int FW = 1 + ADDR_W + DATA_W;
  localparam int CW = $clog2(FW);
  localparam logic [CW-1:0] LAST_BIT = CW'(FW - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, ISSUE, WAIT} state_t;

  state_t state, state_nx;

  logic [SYNC-1:0]   sclk_sync, cs_sync, mosi_sync;
  logic              sclk_q, cs_q, mosi_q;
  logic              sclk_d, cs_d;
  logic              sclk_rise, sclk_fall, cs_fall;

  logic [CW-1:0]     bit_cnt;
  logic [FW-2:0]     rx;
  logic [FW-1:0]     frame;
  logic [ADDR_W-1:0] frame_addr, addr_sel;
  logic              frame_done, accept, drop;

  logic [FW-1:0]     tx;
  logic              tx_ovf;
  logic              ovf;
  logic [DATA_W-1:0] rdata_hold;
  logic [FW-1:0]     status;
  logic              tx_load;

  assign sclk_q = sclk_sync[SYNC-1];
  assign cs_q   = cs_sync[SYNC-1];
  assign mosi_q = mosi_sync[SYNC-1];

  assign sclk_rise = sclk_q & ~sclk_d & ~cs_q;
  assign sclk_fall = ~sclk_q & sclk_d & ~cs_q;
  assign cs_fall   = ~cs_q & cs_d;

  assign frame_done = sclk_rise & (bit_cnt == LAST_BIT);
  assign frame      = {rx, mosi_q};
  assign frame_addr = frame[FW-2:DATA_W];

  // A frame completing while a request is still outstanding is dropped.
  assign accept = frame_done & (state == IDLE || state == SHIFT);
  assign drop   = frame_done & (state == ISSUE || state == WAIT);

  assign dbg_req = (state == ISSUE) || (state == WAIT);

  assign status = {dbg_req, ovf, {(ADDR_W-1){1'b0}}, rdata_hold};
  // Reload at cs fall, and at the first sclk fall after a full frame so that
  // back-to-back frames in one cs assertion each carry a fresh status word.
  assign tx_load = cs_fall | (sclk_fall & (bit_cnt == '0));

  assign spi_miso = ~cs_q & tx[FW-1];

`ifdef SPI_DBG_AUTOINC_EN
  logic [ADDR_W-1:0] addr_ptr;
  logic              first_frame;

  assign addr_sel = first_frame ? frame_addr : addr_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_ptr    <= '0;
      first_frame <= 1'b1;
    end else begin
      if (cs_fall)
        first_frame <= 1'b1;
      else if (frame_done)
        first_frame <= 1'b0;
      if (accept)
        addr_ptr <= addr_sel + ADDR_W'(1);
    end
  end
`else
  assign addr_sel = frame_addr;
`endif

  // Input synchronizers and edge-detect history; cs idles high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC-2:0], spi_clk};
      cs_sync   <= {cs_sync[SYNC-2:0], spi_cs};
      mosi_sync <= {mosi_sync[SYNC-2:0], spi_mosi};
      sclk_d    <= sclk_q;
      cs_d      <= cs_q;
    end
  end

  // Receive path and request capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt   <= '0;
      rx        <= '0;
      dbg_addr  <= '0;
      dbg_wdata <= '0;
      dbg_wr    <= 1'b0;
    end else begin
      if (cs_fall)
        bit_cnt <= '0;
      else if (sclk_rise)
        bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + CW'(1);
      if (sclk_rise)
        rx <= {rx[FW-3:0], mosi_q};
      if (accept) begin
        dbg_wr    <= frame[FW-1];
        dbg_addr  <= addr_sel;
        dbg_wdata <= frame[DATA_W-1:0];
      end
    end
  end

  // Transmit path, read-data hold and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx         <= '0;
      tx_ovf     <= 1'b0;
      ovf        <= 1'b0;
      rdata_hold <= '0;
    end else begin
      if (tx_load) begin
        tx     <= status;
        tx_ovf <= ovf;
      end else if (sclk_fall) begin
        tx <= {tx[FW-2:0], 1'b0};
      end else if (frame_done) begin
        tx_ovf <= 1'b0;
      end
      // A new drop wins over clearing by a fully shifted-out ovf word.
      if (drop)
        ovf <= 1'b1;
      else if (frame_done && tx_ovf)
        ovf <= 1'b0;
      if (dbg_req && dbg_ack && !dbg_wr)
        rdata_hold <= dbg_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (accept) state_nx = ISSUE;
             else if (!cs_q) state_nx = SHIFT;
      SHIFT: if (accept) state_nx = ISSUE;
             else if (cs_q) state_nx = IDLE;
      ISSUE: if (dbg_ack) state_nx = cs_q ? IDLE : SHIFT;
             else state_nx = WAIT;
      WAIT:  if (dbg_ack) state_nx = cs_q ? IDLE : SHIFT;
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_debug_bridge.sv
// tb_spi_debug_bridge
//   Directed plus randomized frames for spi_debug_bridge. A responder process
//   plays the debug bus (auto or forced acks, random read data) and logs every
//   accepted request; the main sequence predicts request fields and status
//   words from the frame format rules.
module tb_spi_debug_bridge;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 16;
  localparam int HALF   = 60;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              spi_clk = 1'b0;
  logic              spi_cs = 1'b1;
  logic              spi_mosi = 1'b0;
  logic              spi_miso;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_wr;
  logic              dbg_req;
  logic              dbg_ack;
  logic [DATA_W-1:0] dbg_rdata;

  spi_debug_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SYNC(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .spi_clk(spi_clk), .spi_cs(spi_cs), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_wr(dbg_wr),
    .dbg_req(dbg_req), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
  } req_t;

  req_t              log_q[$];
  int                checks = 0;
  int                failures = 0;
  logic              ack_en = 1'b0;
  int                force_cnt = 0;
  logic [DATA_W-1:0] force_rdata = '0;

  // Debug-bus responder: forced single ack on request from the main sequence,
  // otherwise auto-ack with a random 0..3 cycle delay when enabled.
  initial begin
    int   served;
    int   wait_cnt;
    int   dly;
    req_t e;
    served = 0; wait_cnt = 0; dly = 1;
    dbg_ack = 1'b0;
    dbg_rdata = '0;
    forever begin
      @(negedge clk);
      dbg_ack = 1'b0;
      if (force_cnt != served) begin
        served = force_cnt;
        if (dbg_req) begin
          e.wr = dbg_wr; e.addr = dbg_addr; e.wdata = dbg_wdata; e.rdata = force_rdata;
          log_q.push_back(e);
        end
        dbg_rdata = force_rdata;
        dbg_ack = 1'b1;
      end else if (dbg_req && ack_en) begin
        if (wait_cnt >= dly) begin
          e.wr = dbg_wr; e.addr = dbg_addr; e.wdata = dbg_wdata; e.rdata = DATA_W'($urandom);
          log_q.push_back(e);
          dbg_rdata = e.rdata;
          dbg_ack = 1'b1;
          wait_cnt = 0;
          dly = $urandom_range(0, 3);
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cs_low();
    spi_cs = 1'b0;
    #(HALF);
  endtask

  task automatic cs_high();
    #(HALF);
    spi_cs = 1'b1;
    #(3*HALF);
  endtask

  task automatic shift_bits(input logic [31:0] w, input int n, output logic [31:0] r);
    r = '0;
    for (int i = 0; i < n; i++) begin
      spi_mosi = w[31-i];
      #(HALF);
      spi_clk = 1'b1;
      r = {r[30:0], spi_miso};
      #(HALF);
      spi_clk = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [31:0] w, output logic [31:0] r);
    cs_low();
    shift_bits(w, 32, r);
    cs_high();
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    step();
    while (!dbg_req && n < 100) begin step(); n++; end
    check(tag, 32'(dbg_req), 32'd1);
  endtask

  task automatic wait_log(input string tag, input int cnt);
    int n = 0;
    while (log_q.size() < cnt && n < 400) begin step(); n++; end
    check(tag, 32'(log_q.size()), 32'(cnt));
  endtask

  // Force one ack; once the ack is visible the request must already be gone.
  task automatic manual_ack(input string tag, input logic [DATA_W-1:0] rd);
    int n = 0;
    step();
    force_rdata = rd;
    force_cnt++;
    step();
    while (!dbg_ack && n < 10) begin step(); n++; end
    check({tag, "_ack_seen"}, 32'(dbg_ack), 32'd1);
    check({tag, "_req_low"}, 32'(dbg_req), 32'd0);
  endtask

  task automatic random_frame(input string tag, inout logic [DATA_W-1:0] hold);
    logic [31:0] w, r;
    int          n0;
    req_t        e;
    w = $urandom;
    n0 = log_q.size();
    ack_en = 1'b1;
    send_frame(w, r);
    check({tag, "_status"}, r, {16'h0000, hold});
    wait_log({tag, "_log"}, n0 + 1);
    if (log_q.size() > n0) begin
      e = log_q[n0];
      check({tag, "_wr"}, 32'(e.wr), 32'(w[31]));
      check({tag, "_addr"}, 32'(e.addr), 32'(w[30:16]));
      check({tag, "_wdata"}, 32'(e.wdata), 32'(w[15:0]));
      if (!e.wr) hold = e.rdata;
    end
  endtask

  initial begin
    logic [31:0]       r;
    logic [DATA_W-1:0] exp_hold;
    int                n0;
    logic [ADDR_W-1:0] exp_addr2;
    exp_hold = '0;

    // Reset state.
    rst_n = 1'b0;
    repeat (3) step();
    check("rst_req", 32'(dbg_req), 32'd0);
    check("rst_wr", 32'(dbg_wr), 32'd0);
    check("rst_addr", 32'(dbg_addr), 32'd0);
    check("rst_wdata", 32'(dbg_wdata), 32'd0);
    check("rst_miso", 32'(spi_miso), 32'd0);
    rst_n = 1'b1;
    repeat (4) step();

    // Directed write.
    send_frame(32'h8123_BEEF, r);
    check("wr_status", r, 32'h0);
    wait_req("wr_req");
    check("wr_wr", 32'(dbg_wr), 32'd1);
    check("wr_addr", 32'(dbg_addr), 32'h0123);
    check("wr_wdata", 32'(dbg_wdata), 32'hBEEF);
    manual_ack("wr", 16'h5555);

    // Directed read; data appears in the next frame's status.
    send_frame(32'h0042_0000, r);
    check("rd_status", r, 32'h0);
    wait_req("rd_req");
    check("rd_wr", 32'(dbg_wr), 32'd0);
    check("rd_addr", 32'(dbg_addr), 32'h0042);
    manual_ack("rd", 16'h1234);
    exp_hold = 16'h1234;

    // Stray ack while idle must not touch the hold register.
    repeat (5) step();
    manual_ack("stray", 16'hDEAD);

    for (int k = 0; k < 6; k++) random_frame($sformatf("rand%0d", k), exp_hold);

    // Aborted frame: no request, next full frame decodes normally.
    n0 = log_q.size();
    cs_low();
    shift_bits(32'hFFFF_FFFF, 20, r);
    cs_high();
    repeat (20) step();
    check("abort_req", 32'(dbg_req), 32'd0);
    check("abort_log", 32'(log_q.size()), 32'(n0));
    random_frame("after_abort", exp_hold);

    // Overflow: second frame while the first request is pending.
    ack_en = 1'b0;
    send_frame(32'h8005_1111, r);
    check("ovf_a_status", r, {16'h0000, exp_hold});
    wait_req("ovf_a_req");
    send_frame(32'h8006_2222, r);
    check("ovf_b_status", r, {2'b10, 14'h0, exp_hold});
    repeat (20) step();
    check("ovf_pend_req", 32'(dbg_req), 32'd1);
    check("ovf_pend_addr", 32'(dbg_addr), 32'h0005);
    check("ovf_pend_wdata", 32'(dbg_wdata), 32'h1111);
    manual_ack("ovf_a", 16'h0);
    n0 = log_q.size();
    ack_en = 1'b1;
    send_frame(32'h0006_0000, r);
    check("ovf_flag_status", r, {2'b01, 14'h0, exp_hold});
    wait_log("ovf_c_log", n0 + 1);
    if (log_q.size() > n0) begin
      check("ovf_c_addr", 32'(log_q[n0].addr), 32'h0006);
      exp_hold = log_q[n0].rdata;
    end
    random_frame("ovf_cleared", exp_hold);

    // Two frames inside one cs assertion.
    n0 = log_q.size();
    ack_en = 1'b1;
    cs_low();
    shift_bits(32'h8010_0001, 32, r);
    check("mf0_status", r, {16'h0000, exp_hold});
    shift_bits(32'h8777_0002, 32, r);
    // busy of the reloaded word depends on ack timing; compare the rest
    check("mf1_status", r & 32'h7FFF_FFFF, {16'h0000, exp_hold});
    cs_high();
    wait_log("mf_log", n0 + 2);
`ifdef SPI_DBG_AUTOINC_EN
    exp_addr2 = 15'h0011;
`else
    exp_addr2 = 15'h0777;
`endif
    if (log_q.size() >= n0 + 2) begin
      check("mf0_addr", 32'(log_q[n0].addr), 32'h0010);
      check("mf1_addr", 32'(log_q[n0+1].addr), 32'(exp_addr2));
      check("mf1_wdata", 32'(log_q[n0+1].wdata), 32'h0002);
    end

    // Reset while a request is pending and MISO is driving a 1.
    ack_en = 1'b0;
    send_frame(32'h8055_AAAA, r);
    wait_req("rstmid_req");
    cs_low();
    check("rstmid_miso_pre", 32'(spi_miso), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rstmid_req_low", 32'(dbg_req), 32'd0);
    check("rstmid_miso_low", 32'(spi_miso), 32'd0);
    check("rstmid_addr", 32'(dbg_addr), 32'd0);
    spi_cs = 1'b1;
    repeat (4) step();
    rst_n = 1'b1;
    repeat (4) step();
    exp_hold = '0;
    random_frame("post_rst", exp_hold);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
